// File: rtl/conv_window_ctrl_pkg.sv
// conv_window_ctrl_pkg: shared CNN geometry defaults and window-controller state encoding
package conv_window_ctrl_pkg;
  localparam int CNN_WIDTH  = 28;
  localparam int CNN_HEIGHT = 28;
  localparam int CNN_FILTER = 5;
  typedef enum logic [1:0] {FILL = 2'd0, SCAN = 2'd1, LOAD = 2'd2} state_t;
endpackage

// File: rtl/mod_counter.sv
// mod_counter: enable-driven counter wrapping MOD-1 -> 0, with synchronous clear
module mod_counter #(
  parameter int MOD = 4,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) o_q <= '0;
    else if (i_clr) o_q <= '0;
    else if (i_en) o_q <= (o_q == W'(MOD - 1)) ? '0 : o_q + 1'b1;
endmodule

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: sequences line-buffer fills/row reloads and sliding-window scans
module conv_window_ctrl import conv_window_ctrl_pkg::*; #(
  parameter int WIDTH       = CNN_WIDTH,
  parameter int HEIGHT      = CNN_HEIGHT,
  parameter int FILTER_SIZE = CNN_FILTER
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic       win_valid,
  input  logic       win_ready,
  output logic [4:0] rd_col,
  output logic [2:0] row_base,
  output logic [4:0] out_row,
  output logic       frame_done
);
  localparam int BUF = WIDTH * FILTER_SIZE;
  localparam int CW  = $clog2(BUF);
  localparam logic [CW-1:0] FILL_LAST = CW'(BUF - 1);
  localparam logic [CW-1:0] LOAD_LAST = CW'(WIDTH - 1);
  localparam logic [4:0]    COL_LAST  = 5'(WIDTH - FILTER_SIZE);
  localparam logic [4:0]    ROW_LAST  = 5'(HEIGHT - FILTER_SIZE);

  state_t        r_state, w_next;
  logic [CW-1:0] r_pix;
  logic [4:0]    r_col, r_row;
  logic          r_done;
  logic          w_fill_last, w_load_last, w_hs, w_row_end, w_frame_end;

  assign in_ready    = r_state != SCAN;
  assign wr_en       = in_valid & in_ready;
  assign win_valid   = r_state == SCAN;
  assign w_fill_last = r_state == FILL && wr_en && r_pix == FILL_LAST;
  assign w_load_last = r_state == LOAD && wr_en && r_pix == LOAD_LAST;
  assign w_hs        = win_valid & win_ready;
  assign w_row_end   = w_hs && r_col == COL_LAST;
  assign w_frame_end = w_row_end && r_row == ROW_LAST;
  assign rd_col      = r_col;
  assign out_row     = r_row;
  assign frame_done  = r_done;

  always_comb
    w_next = (w_fill_last || w_load_last) ? SCAN :
             w_frame_end ? FILL :
             w_row_end ? LOAD : r_state;

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= FILL;
    else r_state <= w_next;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pix  <= '0;
      r_col  <= '0;
      r_row  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_frame_end;
      r_pix  <= (w_fill_last || w_load_last) ? '0 : wr_en ? r_pix + 1'b1 : r_pix;
      r_col  <= w_row_end ? '0 : w_hs ? r_col + 1'b1 : r_col;
      r_row  <= w_frame_end ? '0 : w_load_last ? r_row + 1'b1 : r_row;
    end

  // Write pointer restarts with each frame so every LOAD lands on slot row_base.
  mod_counter #(.MOD(BUF), .W(8)) u_wr_addr (
    .clk(clk), .rst(rst), .i_en(wr_en), .i_clr(w_frame_end), .o_q(wr_addr)
  );

  mod_counter #(.MOD(FILTER_SIZE), .W(3)) u_row_base (
    .clk(clk), .rst(rst), .i_en(w_load_last), .i_clr(w_frame_end), .o_q(row_base)
  );
endmodule
